// File: rtl/instr_encoder_fifo.sv
// instr_encoder_fifo: packs instruction fields into 32-bit words, buffers them in a FIFO and issues them over valid/ready
module instr_encoder_fifo #(
  parameter int DEPTH = 4,
  parameter logic [4:0] OP_MAX = 5'd7,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [AW:0]      level,
  output logic             err_illegal,
  output logic [CNT_W-1:0] issued_cnt
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push, wr, pop;
  always_comb begin
    in_ready = !rst && level < FULL;
    out_valid = level != '0;
    out_instr = out_valid ? mem[rp] : 32'h0;
    push = in_valid && in_ready;
    wr = push && in_op <= OP_MAX;
    pop = out_valid && out_ready;
  end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= {in_op, in_rd, in_rs1, in_rs2, 12'h000};
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
      err_illegal <= 1'b0;
      issued_cnt <= '0;
    end else begin
      wp <= wr ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      level <= level + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
      err_illegal <= err_illegal || (push && in_op > OP_MAX);
      issued_cnt <= issued_cnt + CNT_W'(pop);
    end
  end
endmodule
